// File: rtl/lmsm_sequencer.sv
// Multi-register load/store sequencer: walks a register mask lowest-index-first and
// issues one memory access per set bit, stalling on mem_ack.
module lmsm_sequencer #(
   parameter int          NREG = 8,
   parameter int          AW   = 16,
   parameter int unsigned STEP = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     mode,
   input  logic [NREG-1:0]          mask,
   input  logic [AW-1:0]            base_addr,
   input  logic                     mem_ack,
   output logic                     busy,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [$clog2(NREG)-1:0]  reg_idx,
   output logic                     rf_we,
   output logic                     done,
   output logic [1:0]               dbg_state
);

   localparam int IDXW = $clog2(NREG);

   // Memory handshake: a request is presented while mem_req=1 and completes in any
   // cycle where mem_req=1 and mem_ack=1; until then mem_we, mem_addr and reg_idx hold.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            r_state;
   logic [NREG-1:0]   r_pend;
   logic [AW-1:0]     r_addr;
   logic              r_mode;
   logic              r_busy;
   logic              r_mem_req;
   logic              r_mem_we;
   logic              r_done;

   logic [IDXW-1:0]   w_idx;
   logic [NREG-1:0]   w_pend_nxt;
   logic              w_xfer;

   // Lowest set bit wins, so scan from the top and let lower indices overwrite.
   always_comb begin
      w_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (r_pend[i]) w_idx = IDXW'(i);
      end
   end

   assign w_pend_nxt = r_pend & (r_pend - NREG'(1));
   assign w_xfer     = r_mem_req & mem_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_pend    <= '0;
         r_addr    <= '0;
         r_mode    <= 1'b0;
         r_busy    <= 1'b0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pend <= mask;
                  r_addr <= base_addr;
                  r_mode <= mode;
                  r_busy <= 1'b1;
                  if (mask != '0) begin
                     r_state   <= S_ISSUE;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= mode;
                  end else begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (w_xfer) begin
                  r_pend <= w_pend_nxt;
                  r_addr <= r_addr + AW'(STEP);
                  if (w_pend_nxt == '0) begin
                     r_state   <= S_FINISH;
                     r_mem_req <= 1'b0;
                     r_mem_we  <= 1'b0;
                     r_done    <= 1'b1;
                  end
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign reg_idx   = w_idx;
   assign rf_we     = w_xfer & ~r_mode;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: default 8-register instance plus a
// 16-register, stride-2 instance.
module tb_lmsm_sequencer;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;

   logic        start, mode, mem_ack;
   logic [7:0]  mask;
   logic [15:0] base_addr;
   logic        busy, mem_req, mem_we, rf_we, done;
   logic [15:0] mem_addr;
   logic [2:0]  reg_idx;
   logic [1:0]  dbg_state;

   logic        d2_start, d2_mode, d2_mem_ack;
   logic [15:0] d2_mask;
   logic [15:0] d2_base_addr;
   logic        d2_busy, d2_mem_req, d2_mem_we, d2_rf_we, d2_done;
   logic [15:0] d2_mem_addr;
   logic [3:0]  d2_reg_idx;
   logic [1:0]  d2_dbg_state;

   lmsm_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .mask(mask),
      .base_addr(base_addr), .mem_ack(mem_ack), .busy(busy), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .reg_idx(reg_idx), .rf_we(rf_we),
      .done(done), .dbg_state(dbg_state)
   );

   lmsm_sequencer #(.NREG(16), .AW(16), .STEP(2)) dut2 (
      .clk(clk), .reset(reset), .start(d2_start), .mode(d2_mode), .mask(d2_mask),
      .base_addr(d2_base_addr), .mem_ack(d2_mem_ack), .busy(d2_busy),
      .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr),
      .reg_idx(d2_reg_idx), .rf_we(d2_rf_we), .done(d2_done), .dbg_state(d2_dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   // flags vector order: {mem_req, mem_we, rf_we, done, busy}
   task automatic test_reset;
      reset = 1'b0;
      start = 0; mode = 0; mask = '0; base_addr = '0; mem_ack = 0;
      d2_start = 0; d2_mode = 0; d2_mask = '0; d2_base_addr = '0; d2_mem_ack = 0;
      #3;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00000 || mem_addr !== 16'h0 ||
          reg_idx !== 3'd0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_dut1: flags=%b addr=%h idx=%0d st=%0d exp all zero",
                  {mem_req, mem_we, rf_we, done, busy}, mem_addr, reg_idx, dbg_state);
      end
      checks++;
      if ({d2_mem_req, d2_mem_we, d2_rf_we, d2_done, d2_busy} !== 5'b00000 ||
          d2_mem_addr !== 16'h0 || d2_reg_idx !== 4'd0) begin
         errors++;
         $display("FAIL reset_dut2: flags=%b addr=%h idx=%0d exp all zero",
                  {d2_mem_req, d2_mem_we, d2_rf_we, d2_done, d2_busy}, d2_mem_addr, d2_reg_idx);
      end
      next_cyc;
      next_cyc;
      reset = 1'b1;
      next_cyc;
   endtask

   task automatic test_load_a5;
      logic [2:0] exp_idx [4];
      int pulses;
      exp_idx = '{3'd0, 3'd2, 3'd5, 3'd7};
      pulses = 0;
      mode = 0; mask = 8'hA5; base_addr = 16'h0040; mem_ack = 1; start = 1;
      next_cyc;
      start = 0; mask = 8'hFF; base_addr = 16'h1234; mode = 1;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({mem_req, mem_we, rf_we, done, busy} !== 5'b10101) begin
            errors++;
            $display("FAIL load_flags c%0d: got %b exp 10101", c + 1, {mem_req, mem_we, rf_we, done, busy});
         end
         checks++;
         if (reg_idx !== exp_idx[c] || mem_addr !== 16'h0040 + 16'(c)) begin
            errors++;
            $display("FAIL load_xfer c%0d: idx=%0d addr=%h exp idx=%0d addr=%h",
                     c + 1, reg_idx, mem_addr, exp_idx[c], 16'h0040 + 16'(c));
         end
         if (rf_we) pulses++;
         next_cyc;
      end
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00011) begin
         errors++;
         $display("FAIL load_done: flags=%b exp 00011", {mem_req, mem_we, rf_we, done, busy});
      end
      start = 1; mask = 8'h01; mode = 0;
      next_cyc;
      start = 0;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00000 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL finish_start_ignored: flags=%b st=%0d exp 00000 st=0",
                  {mem_req, mem_we, rf_we, done, busy}, dbg_state);
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL load_rf_we_count: got %0d exp 4", pulses);
      end
      next_cyc;
      checks++;
      if ({mem_req, busy} !== 2'b00) begin
         errors++;
         $display("FAIL load_stay_idle: req/busy=%b exp 00", {mem_req, busy});
      end
      mem_ack = 0;
   endtask

   task automatic test_store_stall;
      logic [2:0]  exp_idx [2];
      logic [15:0] exp_addr [2];
      exp_idx = '{3'd0, 3'd7};
      exp_addr = '{16'h0100, 16'h0101};
      mode = 1; mask = 8'h81; base_addr = 16'h0100; mem_ack = 0; start = 1;
      next_cyc;
      start = 0;
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 3; s++) begin
            mem_ack = (s == 2);
            #1;
            checks++;
            if ({mem_req, mem_we, rf_we, done, busy} !== 5'b11001 ||
                reg_idx !== exp_idx[r] || mem_addr !== exp_addr[r]) begin
               errors++;
               $display("FAIL store_stall r%0d s%0d: flags=%b idx=%0d addr=%h exp 11001 idx=%0d addr=%h",
                        r, s, {mem_req, mem_we, rf_we, done, busy}, reg_idx, mem_addr,
                        exp_idx[r], exp_addr[r]);
            end
            next_cyc;
         end
      end
      mem_ack = 0;
      #1;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00011) begin
         errors++;
         $display("FAIL store_done: flags=%b exp 00011", {mem_req, mem_we, rf_we, done, busy});
      end
      next_cyc;
   endtask

   task automatic test_empty_mask;
      mode = 0; mask = 8'h00; base_addr = 16'h0300; mem_ack = 1; start = 1;
      next_cyc;
      start = 0;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00011) begin
         errors++;
         $display("FAIL empty_c1: flags=%b exp 00011", {mem_req, mem_we, rf_we, done, busy});
      end
      next_cyc;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00000) begin
         errors++;
         $display("FAIL empty_c2: flags=%b exp 00000", {mem_req, mem_we, rf_we, done, busy});
      end
      mem_ack = 0;
   endtask

   task automatic test_wrap;
      mode = 0; mask = 8'h03; base_addr = 16'hFFFF; mem_ack = 1; start = 1;
      next_cyc;
      start = 0;
      checks++;
      if (mem_req !== 1'b1 || reg_idx !== 3'd0 || mem_addr !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_c1: req=%b idx=%0d addr=%h exp 1 0 ffff", mem_req, reg_idx, mem_addr);
      end
      next_cyc;
      checks++;
      if (mem_req !== 1'b1 || reg_idx !== 3'd1 || mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_c2: req=%b idx=%0d addr=%h exp 1 1 0000", mem_req, reg_idx, mem_addr);
      end
      next_cyc;
      checks++;
      if ({mem_req, done} !== 2'b01) begin
         errors++;
         $display("FAIL wrap_done: req/done=%b exp 01", {mem_req, done});
      end
      mem_ack = 0;
      next_cyc;
   endtask

   task automatic test_reset_mid;
      mode = 1; mask = 8'hFF; base_addr = 16'h0200; mem_ack = 1; start = 1;
      next_cyc;
      start = 1; mask = 8'h01; mode = 0; base_addr = 16'h0000;
      next_cyc;
      start = 0;
      next_cyc;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || reg_idx !== 3'd2 || mem_addr !== 16'h0202) begin
         errors++;
         $display("FAIL busy_start_ignored: req=%b we=%b idx=%0d addr=%h exp 1 1 2 0202",
                  mem_req, mem_we, reg_idx, mem_addr);
      end
      reset = 1'b0;
      mem_ack = 0;
      #1;
      checks++;
      if ({mem_req, mem_we, rf_we, done, busy} !== 5'b00000 || dbg_state !== 2'd0 ||
          mem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_async: flags=%b st=%0d addr=%h exp 00000 0 0000",
                  {mem_req, mem_we, rf_we, done, busy}, dbg_state, mem_addr);
      end
      next_cyc;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         next_cyc;
         checks++;
         if ({mem_req, done, busy} !== 3'b000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_after c%0d: req/done/busy=%b st=%0d exp 000 0",
                     c, {mem_req, done, busy}, dbg_state);
         end
      end
   endtask

   task automatic test_nreg16_step2;
      d2_mode = 0; d2_mask = 16'h8001; d2_base_addr = 16'h0000; d2_mem_ack = 1; d2_start = 1;
      next_cyc;
      d2_start = 0;
      checks++;
      if (d2_mem_req !== 1'b1 || d2_rf_we !== 1'b1 || d2_reg_idx !== 4'd0 || d2_mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL n16_c1: req=%b rfwe=%b idx=%0d addr=%h exp 1 1 0 0000",
                  d2_mem_req, d2_rf_we, d2_reg_idx, d2_mem_addr);
      end
      next_cyc;
      checks++;
      if (d2_mem_req !== 1'b1 || d2_reg_idx !== 4'd15 || d2_mem_addr !== 16'h0002) begin
         errors++;
         $display("FAIL n16_c2: req=%b idx=%0d addr=%h exp 1 15 0002", d2_mem_req, d2_reg_idx, d2_mem_addr);
      end
      next_cyc;
      checks++;
      if ({d2_mem_req, d2_done, d2_busy} !== 3'b011) begin
         errors++;
         $display("FAIL n16_done: req/done/busy=%b exp 011", {d2_mem_req, d2_done, d2_busy});
      end
      d2_mem_ack = 0;
      next_cyc;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_a5();
      test_store_stall();
      test_empty_mask();
      test_wrap();
      test_reset_mid();
      test_nreg16_step2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
